uart_rx_ctrl: RTL

UART receive stage that consumes the serial line driven by the transmitter's TX output (tx_out → rx_in). It does the following:
- Oversamples rx_in at 16x baud and detects and validates the start bit.
- Shifts in 8 data bits, LSB first, and checks the stop bit.
- Holds the received byte in a one-deep buffer with an empty flag and an unload strobe, mirroring the transmitter's load/empty handshake.

---
 rtl/uart_rx_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x oversampled start/data/stop framing into a one-deep buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx_ctrl #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_enable,
   input  logic       rx_in,
   input  logic       uld_rx_data,
   output logic [7:0] rx_data,
   output logic       rx_empty,
   output logic       rx_frame_err,
   output logic       rx_over_run,
   output logic       rx_parity_err
);

   localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY    = 3'd3;
`endif

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]       state_q, state_d;
   logic [3:0]       samp_q, samp_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             empty_q, empty_d;
   logic             ferr_q, ferr_d;
   logic             perr_q, perr_d;
   logic             ovr_q, ovr_d;
   logic             line;
   logic             tick;
   logic             complete;
   logic             parity_err_calc;

`ifdef UART_RX_PARITY_EN
   logic par_q, par_d;
   assign parity_err_calc = (^shift_q) ^ par_q;
`else
   assign parity_err_calc = 1'b0;
`endif

   assign line = sync2_q;
   assign tick = (state_q != IDLE) && (state_q != WAIT_HIGH) && (tick_cnt_q == TICK_LAST);

   // Tick divider stays parked at zero while waiting so every frame starts phase-aligned.
   always_comb begin
      sync1_d = rx_in;
      sync2_d = sync1_q;
      if ((state_q == IDLE) || (state_q == WAIT_HIGH) || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      samp_d   = samp_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      complete = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
`endif
      if (tick) begin
         samp_d = samp_q + 4'd1;
      end
      if (!rx_enable && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_enable && !line) begin
                  state_d = START;
                  samp_d  = 4'd0;
               end
            end
            START: begin
               // Mid start bit: a high line here means the falling edge was a glitch.
               if (tick && (samp_q == 4'd7)) begin
                  if (line) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     samp_d  = 4'd0;
                     bit_d   = 3'd0;
                  end
               end
            end
            DATA: begin
               if (tick && (samp_q == 4'd15)) begin
                  shift_d = {line, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick && (samp_q == 4'd15)) begin
                  par_d   = line;
                  state_d = STOP;
               end
            end
`endif
            STOP: begin
               if (tick && (samp_q == 4'd15)) begin
                  complete = 1'b1;
                  state_d  = line ? IDLE : WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (line) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A finishing frame may refill the buffer in the same cycle it is being unloaded.
   always_comb begin
      data_d  = data_q;
      empty_d = empty_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      ovr_d   = ovr_q;
      if (complete) begin
         if (empty_q || uld_rx_data) begin
            data_d  = shift_q;
            empty_d = 1'b0;
            ferr_d  = !line;
            perr_d  = parity_err_calc;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (uld_rx_data && !empty_q) begin
         empty_d = 1'b1;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         tick_cnt_q <= '0;
         state_q    <= IDLE;
         samp_q     <= 4'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         data_q     <= 8'd0;
         empty_q    <= 1'b1;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         empty_q    <= empty_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign rx_data       = data_q;
   assign rx_empty      = empty_q;
   assign rx_frame_err  = ferr_q;
   assign rx_over_run   = ovr_q;
   assign rx_parity_err = perr_q;

endmodule
